// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// driving datapath enables and selects one state at a time and counting retired instructions.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       dec_inst,
  input  logic             zero,
  input  logic             overflow,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_write_en,
  output logic             pc_write_en,
  output logic             ir_write_en,
  output logic             reg_write_en,
  output logic [1:0]       alu_sel,
  output logic             alu_src_ctl,
  output logic [1:0]       ext_ctl,
  output logic [1:0]       npc_sel,
  output logic [1:0]       gpr_write_addr_sel,
  output logic [1:0]       gpr_write_data_sel,
  output logic             halt_sig,
  output logic             bad_inst,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] inst_count
);

  // Encodings mirror defines.v; every default select is encoded as zero.
  localparam logic [5:0] INST_ADDU  = 6'd1,  INST_SUBU = 6'd2,  INST_SLT  = 6'd3;
  localparam logic [5:0] INST_ORI   = 6'd4,  INST_LUI  = 6'd5,  INST_ADDI = 6'd6;
  localparam logic [5:0] INST_ADDIU = 6'd7,  INST_LW   = 6'd8,  INST_SW   = 6'd9;
  localparam logic [5:0] INST_BEQ   = 6'd10, INST_J    = 6'd11, INST_JR   = 6'd12;
  localparam logic [5:0] INST_JAL   = 6'd13, INST_HLT  = 6'd14;

  localparam logic [1:0] ALU_SEL_ADD = 2'd0, ALU_SEL_SUB = 2'd1, ALU_SEL_OR = 2'd2, ALU_SEL_SLT = 2'd3;
  localparam logic       ALU_SRC_EXT = 1'b0, ALU_SRC_GPR = 1'b1;
  localparam logic [1:0] EXT_SEL_SIGN = 2'd0, EXT_SEL_ZERO = 2'd1, EXT_SEL_LUI = 2'd2;
  localparam logic [1:0] IFU_SEL_NORM = 2'd0, IFU_SEL_RELATIVE = 2'd1;
  localparam logic [1:0] IFU_SEL_IRRELATIVE = 2'd2, IFU_SEL_REGISTER = 2'd3;
  localparam logic [1:0] GPR_WRITE_ADDR_RT = 2'd0, GPR_WRITE_ADDR_RD = 2'd1, GPR_WRITE_ADDR_RA = 2'd2;
  localparam logic [1:0] GPR_WRITE_DATA_ALU = 2'd0, GPR_WRITE_DATA_MEM = 2'd1, GPR_WRITE_DATA_PC = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t           cur_state, nxt_state;
  logic             ovf_q;
  logic             retire;
  logic [CNT_W-1:0] count_q;

  assign state      = cur_state;
  assign inst_count = count_q;

  // ADDI's overflow is only valid in EXEC, so it is held for the WB write decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      ovf_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == EXEC) ovf_q <= overflow;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    nxt_state          = cur_state;
    retire             = 1'b0;
    mem_req            = 1'b0;
    mem_sel            = 1'b0;
    mem_write_en       = 1'b0;
    pc_write_en        = 1'b0;
    ir_write_en        = 1'b0;
    reg_write_en       = 1'b0;
    alu_sel            = ALU_SEL_ADD;
    alu_src_ctl        = ALU_SRC_EXT;
    ext_ctl            = EXT_SEL_SIGN;
    npc_sel            = IFU_SEL_NORM;
    gpr_write_addr_sel = GPR_WRITE_ADDR_RT;
    gpr_write_data_sel = GPR_WRITE_DATA_ALU;
    halt_sig           = 1'b0;
    bad_inst           = 1'b0;

    case (cur_state)
      IDLE: nxt_state = FETCH;

      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write_en = 1'b1;
          pc_write_en = 1'b1;
          nxt_state   = DECODE;
        end
      end

      DECODE: begin
        case (dec_inst)
          INST_HLT: nxt_state = HALT;
          INST_ADDU, INST_SUBU, INST_SLT, INST_ORI, INST_LUI, INST_ADDI, INST_ADDIU,
          INST_LW, INST_SW, INST_BEQ, INST_J, INST_JR, INST_JAL: nxt_state = EXEC;
          default: begin
            bad_inst  = 1'b1;
            nxt_state = FETCH;
          end
        endcase
      end

      EXEC: begin
        nxt_state = WB;
        case (dec_inst)
          INST_ADDU: alu_src_ctl = ALU_SRC_GPR;
          INST_SUBU: begin
            alu_sel     = ALU_SEL_SUB;
            alu_src_ctl = ALU_SRC_GPR;
          end
          INST_SLT: begin
            alu_sel     = ALU_SEL_SLT;
            alu_src_ctl = ALU_SRC_GPR;
          end
          INST_ORI: begin
            alu_sel = ALU_SEL_OR;
            ext_ctl = EXT_SEL_ZERO;
          end
          INST_LUI:               ext_ctl   = EXT_SEL_LUI;
          INST_ADDI, INST_ADDIU:  nxt_state = WB;
          INST_LW, INST_SW:       nxt_state = MEM;
          INST_BEQ: begin
            alu_sel     = ALU_SEL_SUB;
            alu_src_ctl = ALU_SRC_GPR;
            if (zero) begin
              pc_write_en = 1'b1;
              npc_sel     = IFU_SEL_RELATIVE;
            end
            retire    = 1'b1;
            nxt_state = FETCH;
          end
          INST_J, INST_JR: begin
            pc_write_en = 1'b1;
            npc_sel     = (dec_inst == INST_J) ? IFU_SEL_IRRELATIVE : IFU_SEL_REGISTER;
            retire      = 1'b1;
            nxt_state   = FETCH;
          end
          // The PC already holds PC+4 here, so it is the link value.
          INST_JAL: begin
            pc_write_en        = 1'b1;
            npc_sel            = IFU_SEL_IRRELATIVE;
            reg_write_en       = 1'b1;
            gpr_write_addr_sel = GPR_WRITE_ADDR_RA;
            gpr_write_data_sel = GPR_WRITE_DATA_PC;
            retire             = 1'b1;
            nxt_state          = FETCH;
          end
          default: nxt_state = FETCH;
        endcase
      end

      MEM: begin
        mem_req      = 1'b1;
        mem_sel      = 1'b1;
        mem_write_en = (dec_inst == INST_SW);
        if (mem_ready) begin
          if (dec_inst == INST_SW) begin
            retire    = 1'b1;
            nxt_state = FETCH;
          end else begin
            nxt_state = WB;
          end
        end
      end

      WB: begin
        reg_write_en = (dec_inst == INST_ADDI) ? ~ovf_q : 1'b1;
        if (dec_inst == INST_ADDU || dec_inst == INST_SUBU || dec_inst == INST_SLT)
          gpr_write_addr_sel = GPR_WRITE_ADDR_RD;
        if (dec_inst == INST_LW)
          gpr_write_data_sel = GPR_WRITE_DATA_MEM;
        retire    = 1'b1;
        nxt_state = FETCH;
      end

      HALT: halt_sig = 1'b1;

      default: nxt_state = IDLE;
    endcase
  end

endmodule
